serial_subtract_ctrl: RTL and testbench



---
 rtl/serial_subtract_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_subtract_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtract_ctrl.sv
// ============================================================================
// serial_subtract_ctrl : bit-serial W-bit subtractor, diff = a - b - borrow_in
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_subtract_ctrl #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  // Holds the W-1 bits already produced; the current bit completes the word.
  logic [W-2:0]  r_q, r_d;
  logic          bor_q, bor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          borrow_out_q, borrow_out_d;
  logic          zero_q, zero_d;

  logic          w_x, w_y, w_z;
  logic          w_d, w_bor;
  logic [W-1:0]  w_res;

  assign w_x   = a_sh_q[0];
  assign w_y   = b_sh_q[0];
  assign w_z   = bor_q;
  assign w_d   = w_x ^ w_y ^ w_z;
  assign w_bor = (~w_x & (w_y ^ w_z)) | (w_y & w_z);
  assign w_res = {w_d, r_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      r_q          <= '0;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      r_q          <= r_d;
      bor_q        <= bor_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    r_d          = r_q;
    bor_d        = bor_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = borrow_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[W-1:1]};
        b_sh_d = {1'b0, b_sh_q[W-1:1]};
        r_d    = w_res[W-1:1];
        bor_d  = w_bor;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d       = w_res;
          borrow_out_d = w_bor;
          zero_d       = (w_res == '0);
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtract_ctrl.sv
// ============================================================================
// tb_serial_subtract_ctrl : scoreboard bench for serial_subtract_ctrl (W=8)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtract_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         ready, busy, done, borrow_out, zero;
  logic [W-1:0] diff;

  serial_subtract_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           acc_c = 0;
  int           last_done = -1;
  bit           checking = 0;
  bit           spacing_chk = 0;
  bit           inflight = 0;
  logic [W-1:0] hold_d = '0;
  logic         hold_bo = 1'b0;
  logic         hold_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi, input int acc);
    exp_t e;
    int   ai, bn, r;
    ai    = int'(av);
    bn    = int'(bv) + int'(bi);
    r     = (ai - bn) & ((1 << W) - 1);
    e.d   = r[W-1:0];
    e.bo  = (ai < bn);
    e.z   = (r == 0);
    e.acc = acc;
    return e;
  endfunction

  // Control model: handshake timing, held outputs, and acceptance of starts.
  always @(negedge clk) begin
    if (checking) begin
      bit eb, ed, er;
      eb = inflight && (cyc < acc_c + W);
      ed = inflight && (cyc == acc_c + W);
      er = !inflight || (cyc > acc_c + W);
      if (inflight && cyc > acc_c + W) inflight = 0;
      check("ready", ready, er);
      check("busy", busy, eb);
      check("done", done, ed);
      if (!eb && !ed) begin
        check("diff_hold", diff, hold_d);
        check("borrow_hold", borrow_out, hold_bo);
        check("zero_hold", zero, hold_z);
      end
      if (!rst_n) begin
        inflight = 0;
        q.delete();
        hold_d  = '0;
        hold_bo = 1'b0;
        hold_z  = 1'b0;
      end else if (er && start) begin
        q.push_back(model(a, b, borrow_in, cyc + 1));
        inflight = 1;
        acc_c    = cyc + 1;
        n_acc++;
      end
    end
  end

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (checking && done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", diff, e.d);
        check("borrow_out", borrow_out, e.bo);
        check("zero", zero, e.z);
        check("latency", cyc, e.acc + W);
        hold_d  = e.d;
        hold_bo = e.bo;
        hold_z  = e.z;
        if (spacing_chk && last_done >= 0) check("done_spacing", cyc - last_done, W + 2);
        last_done = cyc;
      end
    end
  end

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!inflight && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    int  n0;
    bit  ok;
    n0 = n_acc;
    ok = 0;
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (n_acc != n0) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: got accepted=0 expected 1");
    end
  endtask

  task automatic chk_res(input logic [W-1:0] ed, input logic ebo, input logic ez);
    check("dir_diff", diff, ed);
    check("dir_borrow", borrow_out, ebo);
    check("dir_zero", zero, ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    checking = 1;
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op(8'h5A, 8'h3C, 1'b0); wait_drain(); chk_res(8'h1E, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0); wait_drain(); chk_res(8'hFF, 1'b1, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1); wait_drain(); chk_res(8'h00, 1'b0, 1'b1);
    run_op(8'h00, 8'hFF, 1'b1); wait_drain(); chk_res(8'h00, 1'b1, 1'b1);

    // Starts during RUN and DONE must be ignored; operands change mid-run.
    run_op(8'h80, 8'h01, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = (i == 3 || i == 8);
      a = 8'($urandom);
      b = 8'($urandom);
      if (start) begin a = 8'hFF; b = 8'hFF; end
    end
    start = 1'b0;
    wait_drain(); chk_res(8'h7F, 1'b0, 1'b0);

    // Reset mid-run aborts the operation.
    run_op(8'hA5, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    run_op(8'h03, 8'h05, 1'b0); wait_drain(); chk_res(8'hFE, 1'b1, 1'b0);

    // Random regression with start held high.
    begin
      int n0, last, k;
      spacing_chk = 1;
      last_done = -1;
      n0 = n_acc;
      last = n_acc;
      a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
      start = 1'b1;
      k = 0;
      while (n_acc < n0 + 1000 && k < 12000) begin
        @(posedge clk); #1;
        k++;
        if (n_acc != last) begin
          last = n_acc;
          a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
        end
      end
      start = 1'b0;
      check("random_ops", n_acc - n0, 1000);
      wait_drain();
      spacing_chk = 0;
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
